// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: bus widths shared with the
// RAM and MAR, the sequencer state encoding and the round-robin pick.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Winner index: a lone requester wins outright, a tie goes to the port that
  // was not the previous tie winner.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    return (req0 && req1) ? ~last_grant : req1;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of the 16x8 single-port RAM.
// Owns the RAM read latency and tri-state bus turnaround for both requesters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  inout  wire  [DATA_W-1:0] ram_data
);

  state_t              state_q, state_d;
  logic                grant_q;
  logic                last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic                any_req;
  logic                pick;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  assign any_req    = req0 | req1;
  assign pick       = rr_pick(req0, req1, last_grant_q);
  assign pick_we    = pick ? we1    : we0;
  assign pick_addr  = pick ? addr1  : addr0;
  assign pick_wdata = pick ? wdata1 : wdata0;

  // NOTE: every variable written here gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = pick_we ? WRITE : RD_ADDR;
      WRITE:   state_d = DONE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && any_req) begin
        grant_q <= pick;
        addr_q  <= pick_addr;
        wdata_q <= pick_wdata;
        // Only a genuine tie moves the round-robin pointer.
        if (req0 && req1) last_grant_q <= pick;
      end

      if (state_q == RD_DATA) begin
        if (grant_q) rdata1_q <= ram_data;
        else         rdata0_q <= ram_data;
      end
    end
  end

  // RAM control is a pure decode of the state, so the enables are exclusive.
  assign ram_write_enable = (state_q == WRITE);
  assign ram_read_enable  = (state_q == RD_DATA);
  assign ram_address      = addr_q;
  assign ram_data         = ram_write_enable ? wdata_q : {DATA_W{1'bz}};

  assign ack0   = (state_q == DONE) && !grant_q;
  assign ack1   = (state_q == DONE) &&  grant_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);
  assign grant  = grant_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 16x8 single-port RAM with tri-state data bus.
- Port 0 is the CPU memory path (MAR/RAM stage). Port 1 is the program loader / debug writer.
- Each port issues read or write transactions over a req/ack handshake. The arbiter grants round-robin and drives the RAM's address, write_enable and read_enable, and the shared data bus.
- The arbiter owns the RAM's read-latency timing and bus turnaround, so requesters never touch the tri-state bus.

Parameters:
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM word width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 direction: 1 = write, 0 = read; stable while req0 is high
- addr0  in  ADDR_W  port 0 address; stable while req0 is high
- wdata0  in  DATA_W  port 0 write data; stable while req0 is high
- ack0  out  1  one-cycle completion pulse for port 0
- rdata0  out  DATA_W  port 0 read data; valid with ack0, held until the next port-0 read completes
- req1, we1, addr1, wdata1, ack1, rdata1: identical set for port 1
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the port currently being served; holds its value in IDLE
- ram_address  out  ADDR_W  to RAM address
- ram_write_enable  out  1  to RAM write_enable
- ram_read_enable  out  1  to RAM read_enable
- ram_data  inout  DATA_W  to RAM data; arbiter drives it only while ram_write_enable=1, otherwise 'z

Behaviour:
- Reset values (at the first edge with reset=1):
  - state=IDLE; ack0=ack1=0; rdata0=rdata1=0; ram_address=0.
  - ram_write_enable=ram_read_enable=0; ram_data='z.
  - busy=0; grant=0; last_grant=1, so port 0 wins the first tie.
- States: IDLE, WRITE, RD_ADDR, RD_DATA, DONE.
- RAM control is decoded combinationally from the state:
  - ram_write_enable=1 only in WRITE.
  - ram_read_enable=1 only in RD_DATA.
  - The two enables are never high together.
- IDLE:
  - Requests are sampled only here.
  - With a single request, that port is granted.
  - With both requesting, the port != last_grant is granted; last_grant is updated to the winner.
  - On a grant: latch grant, latch ram_address <= addrN, latch the write/read direction and wdata. Next state is WRITE if weN=1, else RD_ADDR.
- WRITE:
  - Drive ram_data = latched wdata; the RAM commits at the end of this cycle.
  - Next state DONE.
- RD_ADDR:
  - Address is stable and enables are low; the RAM buffer captures Memory[address] at the end of this cycle.
  - Next state RD_DATA.
- RD_DATA:
  - The RAM drives ram_data; the arbiter captures it into rdata[grant] at the end of this cycle.
  - Next state DONE.
- DONE:
  - ack[grant]=1 for exactly this cycle; requests are ignored.
  - Next state IDLE. The requester drops req on the edge that samples ack.
- Latency, counting the cycle req is first seen in IDLE as cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 3, with rdata valid in that same cycle.
- Throughput: back-to-back requests from alternating ports are served with one IDLE cycle between transactions.
- ram_address holds the last transaction's address while IDLE.
- If req drops mid-transaction, the transaction still completes and ack is still pulsed.
- Reset mid-operation:
  - Return to IDLE at that edge; no ack is issued; rdata is cleared.
  - If reset coincides with the WRITE cycle, the RAM write still commits (the RAM has no reset).
  - A requester whose transaction was aborted must re-request.
- The data bus is never driven by both the arbiter and the RAM. The arbiter's driver is enabled only in WRITE; the RAM's driver is enabled only in RD_DATA.

Decomposition:
- Shared package ram_arb_pkg holds:
  - the state encoding localparams (IDLE=0, WRITE=1, RD_ADDR=2, RD_DATA=3, DONE=4; 3-bit);
  - ADDR_W/DATA_W defaults, shared with the RAM and MAR.
- No sub-module: the round-robin pick is two lines of logic. Arbiter and FSM stay in a single module.

Test Plan:
- After reset, port 0 reads addr 0xA -> ack0 in cycle 3, rdata0=0x03, ram_read_enable high only in cycle 2, ack1 stays 0.
- Port 1 writes 0x5A to addr 0xF, then port 0 reads 0xF -> ack1 in cycle 2, then rdata0=0x5A; ram_data is never X during either transaction.
- req0 and req1 both rise the cycle after reset (reads of 0xB and 0xC) -> port 0 served first (rdata0=0x02), then port 1 (rdata1=0x01). A second simultaneous pair -> port 1 served first.
- Port 0 read of 0xD with reset asserted during RD_DATA -> no ack0, rdata0=0, state IDLE. A re-request returns 0x05.
- Port 1 write of 0x77 to addr 0x3 with reset asserted during WRITE -> no ack1. A later read of 0x3 returns 0x77.
- req0 dropped during RD_ADDR on a read of 0xE -> ack0 still pulses one cycle later than RD_DATA, with rdata0=0x0A; busy falls in the following cycle.
